// File: rtl/traffic_light_fsm.sv
// Phase controller for a main/side intersection with a pedestrian all-red walk phase.
// Advances only when the countdown timer reports finish on a 1-second tick, and supplies the timer's next reload value.
module traffic_light_fsm #(
  parameter logic [4:0] MG_SEC  = 5'd18,
  parameter logic [4:0] MY_SEC  = 5'd2,
  parameter logic [4:0] SG_SEC  = 5'd12,
  parameter logic [4:0] SY_SEC  = 5'd2,
  parameter logic [4:0] PED_SEC = 5'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       finish,
  input  logic       ped_req,
  output logic [4:0] light_second,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_MG  = 3'd0,
    ST_MY  = 3'd1,
    ST_SG  = 3'd2,
    ST_SY  = 3'd3,
    ST_PED = 3'd4
  } state_e;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  state_e     state_q, state_d;
  logic       ped_pending_q, ped_pending_d;
  logic       ped_ack_q, ped_ack_d;
  logic [2:0] main_rgy_q, main_rgy_d;
  logic [2:0] side_rgy_q, side_rgy_d;
  logic       ped_walk_q, ped_walk_d;
  logic       adv;
  logic       pend_eff;

  assign adv      = finish & en;
  assign pend_eff = ped_pending_q | ped_req;

  // The same pend_eff picks the SY successor and its reload, so the timer and the FSM always agree.
  always_comb begin
    state_d      = state_q;
    light_second = MG_SEC;
    case (state_q)
      ST_MG: begin
        light_second = MY_SEC;
        if (adv) state_d = ST_MY;
      end
      ST_MY: begin
        light_second = SG_SEC;
        if (adv) state_d = ST_SG;
      end
      ST_SG: begin
        light_second = SY_SEC;
        if (adv) state_d = ST_SY;
      end
      ST_SY: begin
        light_second = pend_eff ? PED_SEC : MG_SEC;
        if (adv) state_d = pend_eff ? ST_PED : ST_MG;
      end
      ST_PED: begin
        light_second = MG_SEC;
        if (adv) state_d = ST_MG;
      end
      default: begin
        light_second = MG_SEC;
        state_d      = ST_MG;
      end
    endcase
  end

  // Requests are accepted outside PED only; the SY->PED advance consumes the request and wins over a new set.
  always_comb begin
    ped_ack_d     = ped_req & ~ped_pending_q & (state_q != ST_PED);
    ped_pending_d = ped_pending_q;
    if (adv && (state_q == ST_SY) && pend_eff) begin
      ped_pending_d = 1'b0;
    end else if (ped_ack_d) begin
      ped_pending_d = 1'b1;
    end
  end

  always_comb begin
    main_rgy_d = LAMP_R;
    side_rgy_d = LAMP_R;
    ped_walk_d = 1'b0;
    case (state_d)
      ST_MG:   main_rgy_d = LAMP_G;
      ST_MY:   main_rgy_d = LAMP_Y;
      ST_SG:   side_rgy_d = LAMP_G;
      ST_SY:   side_rgy_d = LAMP_Y;
      ST_PED:  ped_walk_d = 1'b1;
      default: begin
        main_rgy_d = LAMP_R;
        side_rgy_d = LAMP_R;
      end
    endcase
  end

  // Lamps are registered from the next state so they switch together with phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_MG;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
      main_rgy_q    <= LAMP_G;
      side_rgy_q    <= LAMP_R;
      ped_walk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
      main_rgy_q    <= main_rgy_d;
      side_rgy_q    <= side_rgy_d;
      ped_walk_q    <= ped_walk_d;
    end
  end

  assign main_rgy = main_rgy_q;
  assign side_rgy = side_rgy_q;
  assign ped_walk = ped_walk_q;
  assign ped_ack  = ped_ack_q;
  assign phase    = state_q;

endmodule
